// File: rtl/page_fetch_if.sv
// SDRAM read-port bundle between page_fetch (master) and the SDRAM controller (slave).
interface page_fetch_if #(
    parameter int ADDR_WIDTH = 21
);
    logic                  sdr_init_done;
    logic                  sdr_init_ref_vld;
    logic                  app_rd_en;
    logic [ADDR_WIDTH-1:0] app_rd_addr;
    logic                  sdr_rd_en;
    logic [31:0]           sdr_rd_dout;

    modport master (
        input  sdr_init_done,
        input  sdr_init_ref_vld,
        input  sdr_rd_en,
        input  sdr_rd_dout,
        output app_rd_en,
        output app_rd_addr
    );

    modport slave (
        output sdr_init_done,
        output sdr_init_ref_vld,
        output sdr_rd_en,
        output sdr_rd_dout,
        input  app_rd_en,
        input  app_rd_addr
    );
endinterface

// File: rtl/page_fetch.sv
// Prefetches the page image from SDRAM into a pixel FIFO and replays it over the right-aligned page window.
// Optional feature macro: PAGE_FETCH_UNDERFLOW_EN (sticky underflow flag and saturating event counter).
module page_fetch #(
    parameter int WIDTH       = 1920,
    parameter int HEIGHT      = 1080,
    parameter int PAGE_WIDTH  = 300,
    parameter int PAGE_HEIGHT = 500,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_WIDTH  = 21,
    parameter int FIFO_DEPTH  = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    input  logic         hdmi_de,
    page_fetch_if.master sdr,
    output logic [23:0]  page_data,
    output logic         page_vld,
    output logic         underflow,
    output logic [15:0]  underflow_cnt
);
    localparam int PAGE_SIZE = PAGE_WIDTH * PAGE_HEIGHT;
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;
    localparam int RW        = $clog2(PAGE_SIZE + 1);
    localparam int HW        = $clog2(WIDTH);
    localparam int VW        = $clog2(HEIGHT);

    typedef enum logic [1:0] {WAIT_INIT, IDLE, FETCH, DONE} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         req_idx_q, req_idx_d;
    logic                  app_rd_en_q, app_rd_en_d;
    logic [ADDR_WIDTH-1:0] app_rd_addr_q, app_rd_addr_d;
    logic [CW-1:0]         out_q, out_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [HW-1:0]         h_q, h_d;
    logic [VW-1:0]         v_q, v_d;
    logic [23:0]           page_data_q, page_data_d;
    logic                  page_vld_q, page_vld_d;
    logic [23:0]           mem_q [FIFO_DEPTH];

    logic                  fs_s, ret_s, req_s, in_win_s, pop_s, wr_s;
    logic [CW:0]           fill_s;

    // Request arbitration, FIFO bookkeeping, pixel counters and output staging.
    always_comb begin
        fs_s     = frame_start && (state_q != WAIT_INIT);
        ret_s    = sdr.sdr_rd_en && (out_q != CW'(0));
        fill_s   = {1'b0, cnt_q} + {1'b0, out_q};
        req_s    = (state_q == FETCH) && !frame_start && !sdr.sdr_init_ref_vld
                   && (fill_s < (CW+1)'(FIFO_DEPTH)) && !app_rd_en_q
                   && (req_idx_q < RW'(PAGE_SIZE));
        in_win_s = hdmi_de && (h_q >= HW'(WIDTH - PAGE_WIDTH)) && (v_q < VW'(PAGE_HEIGHT));
        pop_s    = in_win_s && (cnt_q != CW'(0));
        wr_s     = sdr.sdr_rd_en && (drop_q == CW'(0)) && !fs_s && (cnt_q != CW'(FIFO_DEPTH));

        state_d = state_q;
        case (state_q)
            WAIT_INIT: if (sdr.sdr_init_done) state_d = IDLE;  else state_d = WAIT_INIT;
            IDLE:      if (frame_start)       state_d = FETCH; else state_d = IDLE;
            FETCH: begin
                if (frame_start)                                    state_d = FETCH;
                else if (req_s && (req_idx_q == RW'(PAGE_SIZE - 1))) state_d = DONE;
                else                                                state_d = FETCH;
            end
            DONE:      if (frame_start)       state_d = FETCH; else state_d = DONE;
            default:   state_d = WAIT_INIT;
        endcase

        if (fs_s)       req_idx_d = RW'(0);
        else if (req_s) req_idx_d = req_idx_q + RW'(1);
        else            req_idx_d = req_idx_q;

        app_rd_en_d = req_s;
        if (req_s) app_rd_addr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(req_idx_q);
        else       app_rd_addr_d = app_rd_addr_q;

        case ({req_s, ret_s})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase

        // Responses already in flight at frame restart belong to the old frame and are discarded.
        if (fs_s) begin
            if (ret_s) drop_d = out_q - CW'(1);
            else       drop_d = out_q;
        end else if (sdr.sdr_rd_en && (drop_q != CW'(0))) begin
            drop_d = drop_q - CW'(1);
        end else begin
            drop_d = drop_q;
        end

        if (fs_s) begin
            wr_ptr_d = PW'(0);
            rd_ptr_d = PW'(0);
            cnt_d    = CW'(0);
        end else begin
            if (wr_s) wr_ptr_d = wr_ptr_q + PW'(1); else wr_ptr_d = wr_ptr_q;
            if (pop_s) rd_ptr_d = rd_ptr_q + PW'(1); else rd_ptr_d = rd_ptr_q;
            case ({wr_s, pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        if (frame_start) begin
            h_d = HW'(0);
            v_d = VW'(0);
        end else if (hdmi_de) begin
            if (h_q == HW'(WIDTH - 1)) begin
                h_d = HW'(0);
                if (v_q == VW'(HEIGHT - 1)) v_d = VW'(0); else v_d = v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
                v_d = v_q;
            end
        end else begin
            h_d = h_q;
            v_d = v_q;
        end

        page_vld_d = in_win_s;
        if (pop_s)         page_data_d = mem_q[rd_ptr_q];
        else if (in_win_s) page_data_d = 24'h000000;
        else               page_data_d = page_data_q;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_INIT;
            req_idx_q     <= RW'(0);
            app_rd_en_q   <= 1'b0;
            app_rd_addr_q <= ADDR_WIDTH'(0);
            out_q         <= CW'(0);
            drop_q        <= CW'(0);
            cnt_q         <= CW'(0);
            wr_ptr_q      <= PW'(0);
            rd_ptr_q      <= PW'(0);
            h_q           <= HW'(0);
            v_q           <= VW'(0);
            page_data_q   <= 24'h000000;
            page_vld_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_idx_q     <= req_idx_d;
            app_rd_en_q   <= app_rd_en_d;
            app_rd_addr_q <= app_rd_addr_d;
            out_q         <= out_d;
            drop_q        <= drop_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            h_q           <= h_d;
            v_q           <= v_d;
            page_data_q   <= page_data_d;
            page_vld_q    <= page_vld_d;
        end
    end

    // Pixel FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_s) mem_q[wr_ptr_q] <= sdr.sdr_rd_dout[23:0];
    end

    assign sdr.app_rd_en   = app_rd_en_q;
    assign sdr.app_rd_addr = app_rd_addr_q;
    assign page_data       = page_data_q;
    assign page_vld        = page_vld_q;

`ifdef PAGE_FETCH_UNDERFLOW_EN
    logic        underflow_q, underflow_d;
    logic [15:0] underflow_cnt_q, underflow_cnt_d;
    logic        uf_ev_s;

    // Underflow event detection with a saturating counter.
    always_comb begin
        uf_ev_s     = in_win_s && (cnt_q == CW'(0));
        underflow_d = underflow_q | uf_ev_s;
        if (uf_ev_s && (underflow_cnt_q != 16'hFFFF)) underflow_cnt_d = underflow_cnt_q + 16'h0001;
        else                                         underflow_cnt_d = underflow_cnt_q;
    end

    // Underflow status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q     <= 1'b0;
            underflow_cnt_q <= 16'h0000;
        end else begin
            underflow_q     <= underflow_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign underflow     = underflow_q;
    assign underflow_cnt = underflow_cnt_q;
`else
    assign underflow     = 1'b0;
    assign underflow_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_page_fetch.sv
// Directed bench for page_fetch on a reduced 16x8 raster with a 4x3 page window and an 8-deep FIFO.
module tb_page_fetch;
    localparam int W    = 16;
    localparam int H    = 8;
    localparam int PGW  = 4;
    localparam int PGH  = 3;
    localparam int BASE = 100;
    localparam int AW   = 12;
    localparam int FD   = 8;
    localparam int HB   = 4;

    logic        clk = 1'b0;
    logic        rst, frame_start, hdmi_de;
    logic [23:0] page_data;
    logic        page_vld, underflow;
    logic [15:0] underflow_cnt;

    page_fetch_if #(.ADDR_WIDTH(AW)) bus ();

    page_fetch #(
        .WIDTH(W), .HEIGHT(H), .PAGE_WIDTH(PGW), .PAGE_HEIGHT(PGH),
        .BASE_ADDR(BASE), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .hdmi_de(hdmi_de),
        .sdr(bus), .page_data(page_data), .page_vld(page_vld),
        .underflow(underflow), .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [23:0] data; } mreq_t;
    typedef struct { int h; int v; logic vld; logic [23:0] data; } vec_t;

    mreq_t       mq[$];
    int          req_log[$];
    int          errors = 0, checks = 0;
    int          cyc = 0, lat = 5, gen = 0, last_due = 0, n_req = 0, vld_cnt = 0;
    int          cur_h = 0, cur_v = 0;
    logic        rec_vld  [W*H];
    logic [23:0] rec_data [W*H];
    logic [23:0] first_data;

    function automatic logic [23:0] pix(input int g, input int a);
        return {4'(g), 8'h5A, 12'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: observe the outputs of the edge just taken, then drive the memory response.
    task automatic tick();
        logic a_de;
        int   a_h, a_v, due;
        a_de = hdmi_de; a_h = cur_h; a_v = cur_v;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mq.delete();
        end else if (bus.app_rd_en) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{due, pix(gen, int'(bus.app_rd_addr))});
            req_log.push_back(int'(bus.app_rd_addr));
            n_req++;
        end
        if (a_de) begin
            rec_vld[a_v*W + a_h]  = page_vld;
            rec_data[a_v*W + a_h] = page_data;
        end
        if (page_vld) begin
            if (vld_cnt == 0) first_data = page_data;
            vld_cnt++;
        end
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            bus.sdr_rd_en   = 1'b1;
            bus.sdr_rd_dout = {8'hEE, mq[0].data};
            void'(mq.pop_front());
        end else begin
            bus.sdr_rd_en   = 1'b0;
            bus.sdr_rd_dout = 32'h0;
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic run_frame();
        for (int i = 0; i < W*H; i++) begin
            rec_vld[i]  = 1'bx;
            rec_data[i] = 24'hxxxxxx;
        end
        vld_cnt    = 0;
        first_data = 24'hxxxxxx;
        for (int v = 0; v < H; v++) begin
            for (int h = 0; h < W; h++) begin
                cur_h = h; cur_v = v; hdmi_de = 1'b1;
                tick();
            end
            hdmi_de = 1'b0;
            repeat (HB) tick();
        end
        repeat (8) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_app_rd_en"},     32'(bus.app_rd_en),   32'h0);
        chk({tag, "_app_rd_addr"},   32'(bus.app_rd_addr), 32'h0);
        chk({tag, "_page_data"},     32'(page_data),       32'h0);
        chk({tag, "_page_vld"},      32'(page_vld),        32'h0);
        chk({tag, "_underflow"},     32'(underflow),       32'h0);
        chk({tag, "_underflow_cnt"}, 32'(underflow_cnt),   32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        int   base;
        vecs[0] = '{12, 0, 1'b1, pix(0, BASE + 0)};
        vecs[1] = '{13, 0, 1'b1, pix(0, BASE + 1)};
        vecs[2] = '{15, 0, 1'b1, pix(0, BASE + 3)};
        vecs[3] = '{ 0, 1, 1'b0, pix(0, BASE + 3)};
        vecs[4] = '{11, 1, 1'b0, pix(0, BASE + 3)};
        vecs[5] = '{12, 1, 1'b1, pix(0, BASE + 4)};
        vecs[6] = '{15, 2, 1'b1, pix(0, BASE + 11)};
        vecs[7] = '{12, 3, 1'b0, pix(0, BASE + 11)};
        vecs[8] = '{15, 7, 1'b0, pix(0, BASE + 11)};

        rst = 1'b1; frame_start = 1'b0; hdmi_de = 1'b0;
        bus.sdr_init_done = 1'b0; bus.sdr_init_ref_vld = 1'b0;
        bus.sdr_rd_en = 1'b0; bus.sdr_rd_dout = 32'h0;
        repeat (2) tick();
        check_reset_outputs("por");
        rst = 1'b0;

        // frame_start before init completes must not start fetching
        base = n_req;
        pulse_fs();
        repeat (10) tick();
        chk("wait_init_no_req", 32'(n_req - base), 32'h0);
        bus.sdr_init_done = 1'b1;
        tick();

        // Test A: prefill then a full frame, latency 5
        lat = 5; gen = 0; base = n_req;
        pulse_fs();
        repeat (60) tick();
        run_frame();
        foreach (vecs[i]) begin
            chk($sformatf("a_vld_%0d_%0d", vecs[i].h, vecs[i].v),
                32'(rec_vld[vecs[i].v*W + vecs[i].h]), 32'(vecs[i].vld));
            chk($sformatf("a_data_%0d_%0d", vecs[i].h, vecs[i].v),
                32'(rec_data[vecs[i].v*W + vecs[i].h]), 32'(vecs[i].data));
        end
        chk("a_vld_count", 32'(vld_cnt), 32'(PGW*PGH));
        chk("a_underflow_cnt", 32'(underflow_cnt), 32'h0);
        repeat (40) tick();
        chk("a_req_count", 32'(n_req - base), 32'(PGW*PGH));
        for (int i = 0; i < PGW*PGH; i++) begin
            chk($sformatf("a_req_addr_%0d", i),
                (base + i < req_log.size()) ? 32'(req_log[base + i]) : 32'hFFFF, 32'(BASE + i));
        end

        // Test B: refresh holds off requests, then they resume promptly from the base address
        bus.sdr_init_ref_vld = 1'b1;
        base = n_req;
        pulse_fs();
        repeat (100) tick();
        chk("b_no_req_in_refresh", 32'(n_req - base), 32'h0);
        bus.sdr_init_ref_vld = 1'b0;
        repeat (2) tick();
        chk("b_resume_within_2", 32'(n_req > base), 32'h1);
        chk("b_first_addr", (n_req > base) ? 32'(req_log[base]) : 32'hFFFF, 32'(BASE));

        // Test C: restart with 8 reads outstanding; old returns must be dropped
        repeat (60) tick();
        chk("c_quiet", 32'(mq.size()), 32'h0);
        lat = 30;
        pulse_fs();
        for (int i = 0; i < 30 && mq.size() < FD; i++) tick();
        chk("c_outstanding", 32'(mq.size()), 32'(FD));
        gen = 1; lat = 5;
        pulse_fs();
        repeat (80) tick();
        run_frame();
        chk("c_first_word", 32'(first_data), 32'(pix(1, BASE)));
        chk("c_second_word", 32'(rec_data[0*W + 13]), 32'(pix(1, BASE + 1)));

        // Test D: latency 40, popping straight after restart starves the window
        gen = 2; lat = 40;
        pulse_fs();
        run_frame();
        chk("d_vld_12_0", 32'(rec_vld[0*W + 12]), 32'h1);
        chk("d_data_12_0", 32'(rec_data[0*W + 12]), 32'h0);
        chk("d_vld_13_1", 32'(rec_vld[1*W + 13]), 32'h1);
        chk("d_data_13_1", 32'(rec_data[1*W + 13]), 32'h0);
        chk("d_vld_count", 32'(vld_cnt), 32'(PGW*PGH));
`ifdef PAGE_FETCH_UNDERFLOW_EN
        chk("d_underflow", 32'(underflow), 32'h1);
        chk("d_underflow_cnt_nonzero", 32'(underflow_cnt != 16'h0), 32'h1);
`else
        chk("d_underflow", 32'(underflow), 32'h0);
        chk("d_underflow_cnt", 32'(underflow_cnt), 32'h0);
`endif

        // Reset mid-FETCH: outputs clear, no requests until init completes again
        repeat (20) tick();
        pulse_fs();
        repeat (5) tick();
        rst = 1'b1; bus.sdr_init_done = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        base = n_req;
        repeat (10) tick();
        pulse_fs();
        repeat (10) tick();
        chk("rst_no_req_before_init", 32'(n_req - base), 32'h0);
        bus.sdr_init_done = 1'b1;
        repeat (2) tick();
        lat = 5; gen = 3;
        pulse_fs();
        for (int i = 0; i < 4 && n_req == base; i++) tick();
        chk("rst_first_addr", (n_req > base) ? 32'(req_log[base]) : 32'hFFFF, 32'(BASE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
